data_mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-ported `DataMemory` (256 x 32-bit words, synchronous write, combinational gated read). It shares the memory between port 0, the CPU load/store unit, and port 1, a loader/DMA engine. Each request is latched, checked for alignment and range, driven onto the memory for exactly one cycle, and answered with a one-cycle `ack` pulse carrying registered read data or an error flag.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/data_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
// Holds the FSM encoding, port identifiers and the address fault rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_DMA  = 1'b1;
    localparam int   MEM_WORDS = 256;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Misaligned, or any bit set above the backed address range.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned abits);
        return (addr[1:0] != 2'b00) || ((addr >> abits) != 32'd0);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: purely combinational, zero latency.
// A lone requester always wins; on a tie the port not granted last wins.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_grant,
    output logic o_owner
);

    always_comb begin
        o_grant = i_req0 | i_req1;
        o_owner = PORT_CPU;
        if (i_req0 && i_req1) begin
            o_owner = ~i_last;
        end else if (i_req1) begin
            o_owner = PORT_DMA;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-ported data memory between the CPU (port 0) and DMA (port 1).
// Latency: request seen in IDLE, memory access next cycle, ack the cycle after; losers wait holding payload.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        r_last;
    logic        r_owner;
    logic        r_err;
    mem_req_t    r_req;
    logic [31:0] r_rdata;

    logic        w_grant;
    logic        w_owner;
    mem_req_t    w_sel_req;

    rr_arbiter2 u_rr (
        .i_req0  (req0),
        .i_req1  (req1),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_owner (w_owner)
    );

    always_comb begin
        w_sel_req.we    = we0;
        w_sel_req.addr  = addr0;
        w_sel_req.wdata = wdata0;
        if (w_owner == PORT_DMA) begin
            w_sel_req.we    = we1;
            w_sel_req.addr  = addr1;
            w_sel_req.wdata = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant) w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last  <= 1'b1;
            r_owner <= PORT_CPU;
            r_err   <= 1'b0;
            r_req   <= '0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_owner;
                        r_req   <= w_sel_req;
                        r_err   <= addr_fault(w_sel_req.addr, ADDR_BITS);
                    end
                end
                // Writes and faulted accesses answer with zero data.
                ST_ACCESS: r_rdata <= (!r_req.we && !r_err) ? mem_read_data : 32'd0;
                ST_RESP:   r_last  <= r_owner;
                default:   ;
            endcase
        end
    end

    always_comb begin
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        ack0           = 1'b0;
        ack1           = 1'b0;
        err0           = 1'b0;
        err1           = 1'b0;
        rdata0         = 32'd0;
        rdata1         = 32'd0;
        case (r_state)
            ST_ACCESS: begin
                if (!r_err) begin
                    mem_address = r_req.addr;
                    if (r_req.we) begin
                        // A reset landing here must not corrupt memory.
                        mem_write      = !reset;
                        mem_write_data = r_req.wdata;
                    end else begin
                        mem_read = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (r_owner == PORT_CPU) begin
                    ack0   = 1'b1;
                    err0   = r_err;
                    rdata0 = r_rdata;
                end else begin
                    ack1   = 1'b1;
                    err1   = r_err;
                    rdata1 = r_rdata;
                end
            end
            default: ;
        endcase
    end

    a_ack_onehot: assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));
    a_rw_onehot:  assert property (@(posedge clk) !(mem_write && mem_read));
    a_access_resp: assert property (@(posedge clk) disable iff (reset)
                                    (r_state == ST_ACCESS) |=> (r_state == ST_RESP));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a transaction-level reference model.
// The model predicts each cycle's outputs from the grant cycle of the transaction in flight.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write, mem_read;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_BITS(10)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    // DataMemory: synchronous write, combinational gated read.
    logic [31:0] mem [0:255];
    assign mem_read_data = mem_read ? mem[mem_address[9:2]] : 32'd0;
    always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_write_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, access at grant+1, ack at grant+2.
    logic [31:0] m_mem [0:255];
    bit          m_act, m_last, m_port, m_we, m_err;
    int          m_start, m_ph;
    bit          m_idle, m_acc, m_resp;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always @(negedge clk) begin
        cyc++;
        if (ack0) ack0_cnt++;
        if (ack1) ack1_cnt++;
        if (reset) begin
            chk1("m_write_in_reset", mem_write, 1'b0);
            m_act  = 0;
            m_last = 1;
        end else begin
            m_ph   = m_act ? cyc - m_start : -1;
            m_acc  = (m_ph == 1);
            m_resp = (m_ph == 2);
            chk1("m_ack0", ack0, m_resp && !m_port);
            chk1("m_ack1", ack1, m_resp && m_port);
            chk1("m_err0", err0, (m_resp && !m_port) ? m_err : 1'b0);
            chk1("m_err1", err1, (m_resp && m_port) ? m_err : 1'b0);
            chk32("m_rdata0", rdata0, (m_resp && !m_port) ? m_rdata : 32'd0);
            chk32("m_rdata1", rdata1, (m_resp && m_port) ? m_rdata : 32'd0);
            chk1("m_mem_read", mem_read, m_acc && !m_err && !m_we);
            chk1("m_mem_write", mem_write, m_acc && !m_err && m_we);
            if (m_acc && !m_err) begin
                chk32("m_mem_address", mem_address, m_addr);
                if (m_we) chk32("m_mem_wdata", mem_write_data, m_wdata);
            end else if (!m_acc) begin
                chk32("m_mem_address_idle", mem_address, 32'd0);
                chk32("m_mem_wdata_idle", mem_write_data, 32'd0);
            end
            m_idle = !m_act;
            if (m_resp) begin
                if (m_we && !m_err) m_mem[m_addr[9:2]] = m_wdata;
                m_last = m_port;
                m_act  = 0;
            end
            if (m_idle && (req0 || req1)) begin
                m_port  = (req0 && req1) ? !m_last : req1;
                m_we    = m_port ? we1 : we0;
                m_addr  = m_port ? addr1 : addr0;
                m_wdata = m_port ? wdata1 : wdata0;
                m_err   = (m_addr % 4 != 0) || (m_addr >= 32'h400);
                m_rdata = (m_we || m_err) ? 32'd0 : m_mem[m_addr / 4];
                m_start = cyc;
                m_act   = 1;
            end
        end
    end

    task automatic drive_port(input bit p, input bit r, input bit we, input logic [31:0] a,
                              input logic [31:0] d);
        if (p) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
    endtask

    // Waits for the port's ack at negedges; n = negedges taken, 0 on timeout.
    task automatic wait_ack(input bit p, output int n, output int wcnt, output int rcnt,
                            output logic [31:0] waddr);
        bit got = 0;
        n = 0; wcnt = 0; rcnt = 0; waddr = 32'd0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_write) begin wcnt++; waddr = mem_address; end
            if (mem_read) rcnt++;
            if (p ? ack1 : ack0) got = 1;
        end
        if (!got) n = 0;
    endtask

    task automatic txn(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input string name, input bit exp_err, input logic [31:0] exp_rd,
                       output int wcnt, output int rcnt, output logic [31:0] waddr);
        int n;
        @(posedge clk); #1;
        drive_port(p, 1, we, a, d);
        wait_ack(p, n, wcnt, rcnt, waddr);
        chk32({name, "_latency"}, 32'(n - 1), 32'd2);
        chk1({name, "_err"}, p ? err1 : err0, exp_err);
        chk32({name, "_rdata"}, p ? rdata1 : rdata0, exp_rd);
        @(posedge clk); #1;
        drive_port(p, 0, 0, 32'd0, 32'd0);
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not complete, got running required finished");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    int          wc, rc, n;
    logic [31:0] wa;
    logic        a0 [0:11];
    logic        a1 [0:11];
    int          acks_before;

    initial begin
        reset = 1'b1;
        drive_port(0, 0, 0, 32'd0, 32'd0);
        drive_port(1, 0, 0, 32'd0, 32'd0);
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 32'h1000 + i;
            m_mem[i] = 32'h1000 + i;
        end
        mem[0] = 32'd10; m_mem[0] = 32'd10;
        mem[1] = 32'd20; m_mem[1] = 32'd20;
        m_act = 0; m_last = 1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_ack0", ack0, 0);  chk1("rst_ack1", ack1, 0);
        chk1("rst_err0", err0, 0);  chk1("rst_err1", err1, 0);
        chk32("rst_rdata0", rdata0, 0); chk32("rst_rdata1", rdata1, 0);
        chk32("rst_mem_address", mem_address, 0);
        chk32("rst_mem_wdata", mem_write_data, 0);
        chk1("rst_mem_write", mem_write, 0); chk1("rst_mem_read", mem_read, 0);
        @(posedge clk); #1 reset = 1'b0;

        txn(0, 0, 32'd0, 32'd0, "rd0_a0", 0, 32'd10, wc, rc, wa);

        txn(1, 1, 32'd8, 32'd30, "wr1_a8", 0, 32'd0, wc, rc, wa);
        chk32("wr1_a8_write_cycles", 32'(wc), 32'd1);
        chk32("wr1_a8_write_addr", wa, 32'd8);
        txn(1, 0, 32'd8, 32'd0, "rd1_a8", 0, 32'd30, wc, rc, wa);

        txn(0, 0, 32'd6, 32'd0, "rd0_misaligned", 1, 32'd0, wc, rc, wa);
        chk32("rd0_misaligned_read_cycles", 32'(rc), 32'd0);
        txn(0, 1, 32'h400, 32'h55, "wr0_range", 1, 32'd0, wc, rc, wa);
        chk32("wr0_range_write_cycles", 32'(wc), 32'd0);
        chk32("wr0_range_mem0", mem[0], 32'd10);

        // Reset landing in the ACCESS cycle of a write
        acks_before = ack0_cnt;
        @(posedge clk); #1 drive_port(0, 1, 1, 32'd4, 32'hDEAD);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk1("rstacc_mem_write", mem_write, 0);
        @(posedge clk); #1 drive_port(0, 0, 0, 32'd0, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        chk32("rstacc_no_ack0", 32'(ack0_cnt - acks_before), 32'd0);
        chk32("rstacc_mem1", mem[1], 32'd20);

        // Continuous contention from reset
        @(posedge clk); #1;
        reset = 1'b1;
        drive_port(0, 1, 0, 32'd0, 32'd0);
        drive_port(1, 1, 0, 32'd8, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            a0[k] = ack0;
            a1[k] = ack1;
            if (k == 2 || k == 8) chk32("cont_rdata0", rdata0, 32'd10);
            if (k == 5 || k == 11) chk32("cont_rdata1", rdata1, 32'd30);
        end
        @(posedge clk); #1;
        drive_port(0, 0, 0, 32'd0, 32'd0);
        drive_port(1, 0, 0, 32'd0, 32'd0);
        for (int k = 0; k < 12; k++) begin
            chk1($sformatf("cont_ack0_k%0d", k), a0[k], (k == 2 || k == 8));
            chk1($sformatf("cont_ack1_k%0d", k), a1[k], (k == 5 || k == 11));
        end

        // Back-to-back on port 1
        @(posedge clk); #1 drive_port(1, 1, 0, 32'd0, 32'd0);
        wait_ack(1, n, wc, rc, wa);
        chk32("b2b_first_latency", 32'(n - 1), 32'd2);
        chk32("b2b_first_rdata", rdata1, 32'd10);
        @(posedge clk); #1 drive_port(1, 1, 0, 32'd4, 32'd0);
        wait_ack(1, n, wc, rc, wa);
        chk32("b2b_ack_spacing", 32'(n), 32'd3);
        chk32("b2b_second_rdata", rdata1, 32'd20);
        @(posedge clk); #1 drive_port(1, 0, 0, 32'd0, 32'd0);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
